rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: the ALU writeback path (A) and the load/memory writeback path (M). It arbitrates round-robin with a valid/ready handshake per requester and registers the winning write into a one-stage output register that drives the register file write port. It also flags read-after-write hazards on the two decode-stage read addresses and counts arbitration conflicts for performance debug.

---
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between
// the ALU and load writeback paths, with RAW hazard and conflict count.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid_i,
    input  logic [AW-1:0] a_wa_i,
    input  logic [DW-1:0] a_wd_i,
    output logic          a_ready_o,
    input  logic          m_valid_i,
    input  logic [AW-1:0] m_wa_i,
    input  logic [DW-1:0] m_wd_i,
    output logic          m_ready_o,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_wa_o,
    output logic [DW-1:0] rf_wd_o,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic          hz1_o,
    output logic          hz2_o,
    output logic [15:0]   conf_cnt_o
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_M = 1'b1
    } prio_e;

    prio_e         prio_q, prio_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          conflict;
    logic          grant_a, grant_m;
    logic [AW-1:0] win_wa;
    logic [DW-1:0] win_wd;

    function automatic logic hit(input logic [AW-1:0] ra);
        return (ra != '0) &&
               ((we_q && wa_q == ra) ||
                (a_valid_i && a_wa_i == ra) ||
                (m_valid_i && m_wa_i == ra));
    endfunction

    always_comb begin
        conflict = a_valid_i && m_valid_i;
        // Ready is forced low while reset is held.
        grant_a  = rst_n && a_valid_i &&
                   (!m_valid_i || prio_q == PRIO_A);
        grant_m  = rst_n && m_valid_i &&
                   (!a_valid_i || prio_q == PRIO_M);
        win_wa   = grant_m ? m_wa_i : a_wa_i;
        win_wd   = grant_m ? m_wd_i : a_wd_i;

        prio_d = prio_q;
        if (conflict) begin
            prio_d = grant_a ? PRIO_M : PRIO_A;
        end

        // Writes to $zero are accepted but never presented.
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if ((grant_a || grant_m) && win_wa != '0) begin
            we_d = 1'b1;
            wa_d = win_wa;
            wd_d = win_wd;
        end

        cnt_d = cnt_q;
        if (conflict && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PRIO_A;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            prio_q <= prio_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign a_ready_o  = grant_a;
    assign m_ready_o  = grant_m;
    assign rf_we_o    = we_q;
    assign rf_wa_o    = wa_q;
    assign rf_wd_o    = wd_q;
    assign hz1_o      = hit(ra1_i);
    assign hz2_o      = hit(ra2_i);
    assign conf_cnt_o = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus randomized bench for rf_wb_arbiter against a
// transaction-level reference model.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid_i, m_valid_i;
    logic [4:0]  a_wa_i, m_wa_i, ra1_i, ra2_i;
    logic [31:0] a_wd_i, m_wd_i;
    logic        a_ready_o, m_ready_o, rf_we_o, hz1_o, hz2_o;
    logic [4:0]  rf_wa_o;
    logic [31:0] rf_wd_o;
    logic [15:0] conf_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          e_last_conf_win;  // 0 = A, 1 = M
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    int          e_cnt;

    // Random phase pending requests
    logic        pa, pm;
    logic [4:0]  paw, pmw;
    logic [31:0] pad, pmd;
    logic        acc_a, acc_m;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_valid_i), .a_wa_i(a_wa_i),
        .a_wd_i(a_wd_i), .a_ready_o(a_ready_o),
        .m_valid_i(m_valid_i), .m_wa_i(m_wa_i),
        .m_wd_i(m_wd_i), .m_ready_o(m_ready_o),
        .rf_we_o(rf_we_o), .rf_wa_o(rf_wa_o),
        .rf_wd_o(rf_wd_o),
        .ra1_i(ra1_i), .ra2_i(ra2_i),
        .hz1_o(hz1_o), .hz2_o(hz2_o),
        .conf_cnt_o(conf_cnt_o)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_last_conf_win = 1;
        e_we  = 1'b0;
        e_wa  = '0;
        e_wd  = '0;
        e_cnt = 0;
    endtask

    function automatic logic e_hz(input logic [4:0] ra);
        if (ra == 0) return 1'b0;
        return (e_we && e_wa == ra) ||
               (a_valid_i && a_wa_i == ra) ||
               (m_valid_i && m_wa_i == ra);
    endfunction

    // One clock: drive at negedge, check comb, model edge, check regs.
    task automatic cyc(input logic av, input logic [4:0] aw,
                       input logic [31:0] ad,
                       input logic mv, input logic [4:0] mw,
                       input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2,
                       output logic ga, output logic gm);
        a_valid_i = av; a_wa_i = aw; a_wd_i = ad;
        m_valid_i = mv; m_wa_i = mw; m_wd_i = md;
        ra1_i = r1; ra2_i = r2;
        #1;
        ga = 1'b0;
        gm = 1'b0;
        if (av && mv) begin
            if (e_last_conf_win == 0) gm = 1'b1;
            else ga = 1'b1;
            e_last_conf_win = ga ? 0 : 1;
        end else if (av) begin
            ga = 1'b1;
        end else if (mv) begin
            gm = 1'b1;
        end
        chk("a_ready", a_ready_o, ga);
        chk("m_ready", m_ready_o, gm);
        chk("hz1", hz1_o, e_hz(r1));
        chk("hz2", hz2_o, e_hz(r2));
        e_we = 1'b0;
        if (ga && aw != 0) begin
            e_we = 1'b1; e_wa = aw; e_wd = ad;
        end
        if (gm && mw != 0) begin
            e_we = 1'b1; e_wa = mw; e_wd = md;
        end
        if (av && mv && e_cnt < 65535) e_cnt++;
        @(posedge clk);
        #1;
        chk("rf_we", rf_we_o, e_we);
        chk("rf_wa", rf_wa_o, e_wa);
        chk("rf_wd", rf_wd_o, e_wd);
        chk("conf_cnt", conf_cnt_o, e_cnt);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        logic ga, gm;
        cyc(0, 0, 0, 0, 0, 0, r1, r2, ga, gm);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid_i = 0; m_valid_i = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic ga, gm;
        a_wa_i = 0; a_wd_i = 0; m_wa_i = 0; m_wd_i = 0;
        ra1_i = 0; ra2_i = 0;
        do_reset();

        #1;
        chk("rst_we", rf_we_o, 0);
        chk("rst_wa", rf_wa_o, 0);
        chk("rst_wd", rf_wd_o, 0);
        chk("rst_cnt", conf_cnt_o, 0);
        chk("rst_hz1", hz1_o, 0);
        @(negedge clk);
        cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, ga, gm);
        chk("rst_first_a", ga, 1);

        // Single source with one-cycle latency
        do_reset();
        cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0, ga, gm);
        chk("single_wa", rf_wa_o, 5);
        chk("single_wd", rf_wd_o, 32'h1234);
        idle(0, 0);
        chk("single_drop", rf_we_o, 0);

        // Contention alternates A, M, A, M
        do_reset();
        cyc(1, 1, 32'hA0, 1, 2, 32'hB0, 0, 0, ga, gm);
        chk("cont0", rf_wd_o, 32'hA0);
        cyc(1, 1, 32'hA1, 1, 2, 32'hB0, 0, 0, ga, gm);
        chk("cont1", rf_wd_o, 32'hB0);
        cyc(1, 1, 32'hA1, 1, 2, 32'hB1, 0, 0, ga, gm);
        chk("cont2", rf_wd_o, 32'hA1);
        cyc(1, 1, 32'hA2, 1, 2, 32'hB1, 0, 0, ga, gm);
        chk("cont3", rf_wd_o, 32'hB1);
        chk("conf4", conf_cnt_o, 4);

        // $zero write accepted and dropped
        cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, ga, gm);
        chk("zero_acc", gm, 1);
        chk("zero_we", rf_we_o, 0);
        chk("zero_wd", rf_wd_o, 32'hB1);

        // Hazard from request, then from output register
        cyc(0, 0, 0, 1, 7, 32'h77, 0, 7, ga, gm);
        #1 chk("hz_reg", hz2_o, 1);
        idle(0, 7);
        #1 chk("hz_clear", hz2_o, 0);

        // Reset the cycle after acceptance
        cyc(1, 9, 32'h99, 0, 0, 0, 0, 0, ga, gm);
        chk("pre_rst_we", rf_we_o, 1);
        a_valid_i = 1; m_valid_i = 1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", rf_we_o, 0);
        chk("mid_rst_wd", rf_wd_o, 0);
        chk("mid_rst_ar", a_ready_o, 0);
        chk("mid_rst_mr", m_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(1, 3, 32'h5, 1, 3, 32'h6, 3, 0, ga, gm);
        chk("post_rst_a", ga, 1);
        chk("post_rst_cnt", conf_cnt_o, 1);

        // Randomized traffic with held requests
        do_reset();
        pa = 0; pm = 0;
        paw = 0; pmw = 0; pad = 0; pmd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1; paw = 5'($urandom_range(0, 7));
                pad = $urandom;
            end
            if (!pm && $urandom_range(0, 2) != 0) begin
                pm = 1; pmw = 5'($urandom_range(0, 7));
                pmd = $urandom;
            end
            cyc(pa, pa ? paw : 5'($urandom), pad,
                pm, pm ? pmw : 5'($urandom), pmd,
                5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), acc_a, acc_m);
            if (acc_a) pa = 0;
            if (acc_m) pm = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
